// File: rtl/ring_osc_trim_ctrl_if.sv
// Control/status bundle between the PLL loop controller (master) and the
// ring oscillator trim sequencer (slave).
interface ring_osc_trim_ctrl_if #(
    parameter int NSTAGES = 13,
    parameter int FRAC_W  = 4
);
    localparam int CW = $clog2(2 * NSTAGES + 1);

    logic                    enable;
    logic                    freeze;
    logic [CW-1:0]           target;
    logic [FRAC_W-1:0]       target_frac;
    logic                    osc_reset;
    logic [2*NSTAGES-1:0]    trim;
    logic [CW-1:0]           code;
    logic                    settled;

    modport master (
        output enable, freeze, target, target_frac,
        input  osc_reset, trim, code, settled
    );

    modport slave (
        input  enable, freeze, target, target_frac,
        output osc_reset, trim, code, settled
    );
endinterface

// File: rtl/ring_osc_trim_ctrl.sv
// Ring oscillator trim sequencer: start-up reset, one-bit-per-step thermometer
// slew toward a clamped target, lock report. Optional trim dither: TRIM_DITHER_EN.
module ring_osc_trim_ctrl #(
    parameter int NSTAGES   = 13,
    parameter int STEP_DIV  = 16,
    parameter int RST_CYC   = 4,
    parameter int INIT_CODE = 13,
    parameter int FRAC_W    = 4
) (
    input  logic                   clk,
    input  logic                   resetb,
    ring_osc_trim_ctrl_if.slave    tc
);
    localparam int TW = 2 * NSTAGES;
    localparam int CW = $clog2(TW + 1);
    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [CW-1:0] MAX_CODE = CW'(TW);
    localparam logic [CW-1:0] INIT_VAL = CW'(INIT_CODE);
    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_HOLD = 2'd1,
        SLEW     = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    state_t          state_r, state_nx_s;
    logic [DW-1:0]   div_r, div_nx_s;
    logic [RW-1:0]   cnt_r, cnt_nx_s;
    logic [CW-1:0]   code_r, code_nx_s, tgt_s, step_code_s;
    logic [TW-1:0]   trim_r, trim_nx_s;
    logic            osc_reset_r, settled_r;

    function automatic logic [TW-1:0] thermo(input logic [CW-1:0] c);
        logic [TW-1:0] t;
        t = '0;
        for (int j = 0; j < TW; j++) begin
            t[j] = (j < int'(c));
        end
        return t;
    endfunction

    assign tgt_s       = (tc.target > MAX_CODE) ? MAX_CODE : tc.target;
    assign step_code_s = (tgt_s > code_r) ? (code_r + CW'(1)) : (code_r - CW'(1));

    // Next-state, divider, reset counter and integer code
    always_comb begin
        state_nx_s = state_r;
        div_nx_s   = div_r;
        cnt_nx_s   = cnt_r;
        code_nx_s  = code_r;
        case (state_r)
            IDLE: begin
                code_nx_s = '0;
                div_nx_s  = '0;
                cnt_nx_s  = '0;
                if (tc.enable) begin
                    state_nx_s = RST_HOLD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RST_HOLD: begin
                if (!tc.enable) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = '0;
                    code_nx_s  = '0;
                end else if (cnt_r == RST_LAST) begin
                    state_nx_s = SLEW;
                    cnt_nx_s   = '0;
                    div_nx_s   = '0;
                    code_nx_s  = INIT_VAL;
                end else begin
                    cnt_nx_s   = cnt_r + RW'(1);
                end
            end
            SLEW: begin
                if (!tc.enable) begin
                    state_nx_s = IDLE;
                    div_nx_s   = '0;
                    code_nx_s  = '0;
                end else if (code_r == tgt_s) begin
                    state_nx_s = LOCKED;
                    div_nx_s   = '0;
                end else if (tc.freeze) begin
                    state_nx_s = SLEW;
                end else if (div_r == DIV_LAST) begin
                    div_nx_s   = '0;
                    code_nx_s  = step_code_s;
                end else begin
                    div_nx_s   = div_r + DW'(1);
                end
            end
            LOCKED: begin
                if (!tc.enable) begin
                    state_nx_s = IDLE;
                    div_nx_s   = '0;
                    code_nx_s  = '0;
                end else if (code_r != tgt_s) begin
                    // The leaving edge already counts as the first divider tick
                    state_nx_s = SLEW;
                    if (tc.freeze) begin
                        div_nx_s  = div_r;
                    end else if (div_r == DIV_LAST) begin
                        div_nx_s  = '0;
                        code_nx_s = step_code_s;
                    end else begin
                        div_nx_s  = div_r + DW'(1);
                    end
                end else begin
                    div_nx_s   = '0;
                end
            end
            default: begin
                state_nx_s = IDLE;
                div_nx_s   = '0;
                cnt_nx_s   = '0;
                code_nx_s  = '0;
            end
        endcase
    end

`ifdef TRIM_DITHER_EN
    logic [FRAC_W-1:0] acc_r, acc_nx_s;
    logic              carry_s;
    logic [CW-1:0]     code_up_s;

    // Fraction accumulator runs only while the loop stays locked
    always_comb begin
        acc_nx_s = '0;
        carry_s  = 1'b0;
        if (state_r == LOCKED && state_nx_s == LOCKED) begin
            {carry_s, acc_nx_s} = {1'b0, acc_r} + {1'b0, tc.target_frac};
        end else begin
            acc_nx_s = '0;
            carry_s  = 1'b0;
        end
    end

    assign code_up_s = (code_nx_s == MAX_CODE) ? MAX_CODE : (code_nx_s + CW'(1));
    assign trim_nx_s = carry_s ? thermo(code_up_s) : thermo(code_nx_s);

    // Accumulator register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_nx_s;
        end
    end
`else
    assign trim_nx_s = thermo(code_nx_s);
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r     <= IDLE;
            div_r       <= '0;
            cnt_r       <= '0;
            code_r      <= '0;
            trim_r      <= '0;
            osc_reset_r <= 1'b1;
            settled_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            div_r       <= div_nx_s;
            cnt_r       <= cnt_nx_s;
            code_r      <= code_nx_s;
            trim_r      <= trim_nx_s;
            osc_reset_r <= (state_nx_s == IDLE) || (state_nx_s == RST_HOLD);
            settled_r   <= (state_nx_s == LOCKED);
        end
    end

    assign tc.osc_reset = osc_reset_r;
    assign tc.trim      = trim_r;
    assign tc.code      = code_r;
    assign tc.settled   = settled_r;
endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// Self-checking bench for ring_osc_trim_ctrl (NSTAGES=13, STEP_DIV=4, RST_CYC=4, INIT_CODE=13).
module tb_ring_osc_trim_ctrl;
    localparam int NS = 13;
    localparam int TW = 2 * NS;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ring_osc_trim_ctrl_if #(.NSTAGES(NS), .FRAC_W(4)) bus ();

    ring_osc_trim_ctrl #(
        .NSTAGES(NS), .STEP_DIV(4), .RST_CYC(4), .INIT_CODE(13), .FRAC_W(4)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .tc     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          frz;
        logic [CW-1:0] tgt;
        int            cyc;
        logic          osc;
        logic [CW-1:0] code;
        logic          stl;
    } vec_t;

    vec_t vecs[21];
    vec_t sb_q[$];

    function automatic logic [TW-1:0] exp_thermo(input int c);
        logic [TW-1:0] t;
        t = '0;
        for (int j = 0; j < c; j++) t[j] = 1'b1;
        return t;
    endfunction

    task automatic cmp_outputs(input string name, input logic osc, input logic [CW-1:0] code,
                               input logic stl);
        logic [TW-1:0] et;
        et = exp_thermo(int'(code));
        checks++;
        if (bus.osc_reset !== osc || bus.code !== code || bus.settled !== stl || bus.trim !== et) begin
            errors++;
            $display("FAIL %s: got osc=%b code=%0d settled=%b trim=%h, want osc=%b code=%0d settled=%b trim=%h",
                     name, bus.osc_reset, bus.code, bus.settled, bus.trim, osc, code, stl, et);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants: single-bit trim motion while running, code bounds
    logic [TW-1:0] prev_trim = '0;
    logic          prev_osc  = 1'b1;
    always @(posedge clk) begin
        #1;
        if (resetb) begin
            checks++;
            if (bus.code > CW'(TW)) begin
                errors++;
                $display("FAIL code_range: got %0d, want <= %0d", bus.code, TW);
            end
            if (!bus.osc_reset && !prev_osc) begin
                checks++;
                if ($countones(bus.trim ^ prev_trim) > 1) begin
                    errors++;
                    $display("FAIL trim_one_bit: got %h after %h, want <=1 bit change",
                             bus.trim, prev_trim);
                end
`ifndef TRIM_DITHER_EN
                checks++;
                if ($countones(bus.trim) != int'(bus.code)) begin
                    errors++;
                    $display("FAIL trim_popcount: got %0d, want %0d",
                             $countones(bus.trim), bus.code);
                end
`endif
            end
        end
        prev_trim = bus.trim;
        prev_osc  = bus.osc_reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          en    frz   tgt     cyc  osc   code   stl
        vecs[0]  = '{1'b0, 1'b0, 5'd13,   3, 1'b1, 5'd0,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5'd13,   4, 1'b1, 5'd0,  1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd13,   1, 1'b0, 5'd13, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd13,   1, 1'b0, 5'd13, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 5'd20,   1, 1'b0, 5'd13, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'd20,   3, 1'b0, 5'd14, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 5'd20,  23, 1'b0, 5'd19, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 5'd20,   1, 1'b0, 5'd20, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 5'd20,   1, 1'b0, 5'd20, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 5'd31,  24, 1'b0, 5'd26, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 5'd31,   1, 1'b0, 5'd26, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 5'd31,  20, 1'b0, 5'd26, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 5'd0,  103, 1'b0, 5'd1,  1'b0};
        vecs[13] = '{1'b1, 1'b0, 5'd0,    1, 1'b0, 5'd0,  1'b0};
        vecs[14] = '{1'b1, 1'b0, 5'd0,    1, 1'b0, 5'd0,  1'b1};
        vecs[15] = '{1'b1, 1'b0, 5'd5,    6, 1'b0, 5'd1,  1'b0};
        vecs[16] = '{1'b1, 1'b1, 5'd5,   10, 1'b0, 5'd1,  1'b0};
        vecs[17] = '{1'b1, 1'b0, 5'd5,    1, 1'b0, 5'd1,  1'b0};
        vecs[18] = '{1'b1, 1'b0, 5'd5,    1, 1'b0, 5'd2,  1'b0};
        vecs[19] = '{1'b0, 1'b1, 5'd5,    1, 1'b1, 5'd0,  1'b0};
        vecs[20] = '{1'b0, 1'b0, 5'd5,    5, 1'b1, 5'd0,  1'b0};

        bus.enable      = 1'b0;
        bus.freeze      = 1'b0;
        bus.target      = '0;
        bus.target_frac = '0;
        #12;
        cmp_outputs("reset_state", 1'b1, 5'd0, 1'b0);
        resetb = 1'b1;
        tick(1);

        for (int i = 0; i < 21; i++) begin
            bus.enable = vecs[i].en;
            bus.freeze = vecs[i].frz;
            bus.target = vecs[i].tgt;
            sb_q.push_back(vecs[i]);
            tick(vecs[i].cyc);
            begin
                vec_t e;
                e = sb_q.pop_front();
                cmp_outputs($sformatf("vec%0d", i), e.osc, e.code, e.stl);
            end
        end

`ifdef TRIM_DITHER_EN
        begin
            int hits;
            bus.enable      = 1'b1;
            bus.target      = 5'd10;
            bus.target_frac = 4'd4;
            tick(20);
            cmp_outputs("dither_lock10", 1'b0, 5'd10, 1'b1);
            hits = 0;
            for (int c = 0; c < 16; c++) begin
                tick(1);
                if ($countones(bus.trim) == 11) hits++;
                checks++;
                if (bus.code !== 5'd10) begin
                    errors++;
                    $display("FAIL dither_code: got %0d, want 10", bus.code);
                end
            end
            checks++;
            if (hits != 4) begin
                errors++;
                $display("FAIL dither_duty: got %0d of 16, want 4", hits);
            end
            bus.target      = 5'd26;
            bus.target_frac = 4'd15;
            tick(66);
            for (int c = 0; c < 16; c++) begin
                tick(1);
                checks++;
                if (bus.trim !== {TW{1'b1}}) begin
                    errors++;
                    $display("FAIL dither_top: got %h, want 3ffffff", bus.trim);
                end
            end
            bus.enable      = 1'b0;
            bus.target_frac = 4'd0;
            tick(2);
        end
`endif

        // Asynchronous reset while slewing
        bus.enable = 1'b1;
        bus.target = 5'd20;
        tick(8);
        cmp_outputs("pre_reset_slew", 1'b0, 5'd13, 1'b0);
        #2;
        resetb = 1'b0;
        #1;
        cmp_outputs("async_reset", 1'b1, 5'd0, 1'b0);
        bus.enable = 1'b0;
        @(posedge clk);
        #3;
        resetb = 1'b1;
        tick(3);
        cmp_outputs("post_reset_idle", 1'b1, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
